gram_blitter: RTL and testbench

//  Writer side of the 1-bit 160x120 graphics frame buffer that the VGA display scans out.

---
 rtl/gram_pkg.sv | 23 ++
 rtl/gram_blitter_addr_gen.sv | 62 ++++++
 rtl/gram_blitter.sv | 131 +++++++++++++
 tb/tb_gram_blitter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gram_pkg.sv
// Shared constants and types for the graphics RAM blitter.
package gram_pkg;

    // Frame buffer geometry, 1 bit per pixel, row-major.
    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int FB_AW = 15;

    // Raster operation applied between sprite pixel and frame buffer pixel.
    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VB = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } blit_state_t;

endpackage

// File: rtl/gram_blitter_addr_gen.sv
// Pixel walker for the blitter: row/col counters, sprite ROM and frame
// buffer address arithmetic, and the off-screen clip flag.
module blit_addr_gen #(
    parameter int FB_W   = gram_pkg::FB_W,
    parameter int FB_H   = gram_pkg::FB_H,
    parameter int FB_AW  = gram_pkg::FB_AW,
    parameter int SRC_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic              size_sel,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [7:0]        dst_x,
    input  logic [6:0]        dst_y,
    output logic [SRC_AW-1:0] src_addr,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              clip,
    output logic              last
);
    import gram_pkg::*;

    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  n_max;
    logic [7:0]  row_off;
    logic [8:0]  col_sum;
    logic [7:0]  row_sum;
    logic [17:0] fb_lin;

    assign n_max = size_sel ? 4'd15 : 4'd7;

    // Raster walk: col steps every pixel, row steps when col wraps.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (advance) begin
            if (col == n_max) begin
                col <= 4'd0;
                row <= row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

    // Sprite row stride is N, so the row offset is row*8 or row*16.
    assign row_off  = size_sel ? {row, 4'b0000} : {1'b0, row, 3'b000};
    assign src_addr = src_base + SRC_AW'(row_off) + SRC_AW'(col);

    // Sums are kept wide enough that off-screen pixels never wrap back on screen.
    assign col_sum  = {1'b0, dst_x} + {5'b0, col};
    assign row_sum  = {1'b0, dst_y} + {4'b0, row};
    assign fb_lin   = 18'(row_sum) * 18'(FB_W) + 18'(col_sum);
    assign fb_addr  = fb_lin[FB_AW-1:0];

    assign clip = (col_sum >= 9'(FB_W)) || (row_sum >= 8'(FB_H));
    assign last = (col == n_max) && (row == n_max);

endmodule

// File: rtl/gram_blitter.sv
// Sprite-to-frame-buffer blitter: latches a draw request, optionally waits
// for frame end, then does read/write pixel pairs over an N x N sprite.
//
// Handshake: start is a request pulse taken only in a cycle where the FSM is
// IDLE (busy==0 and done==0); the request fields are captured on that edge.
// busy is high from the cycle after acceptance until the last write; done
// pulses for one cycle after the last write with busy low; a start seen in the
// done cycle is dropped, the next cycle accepts again.
module gram_blitter #(
    parameter int FB_W        = gram_pkg::FB_W,
    parameter int FB_H        = gram_pkg::FB_H,
    parameter int FB_AW       = gram_pkg::FB_AW,
    parameter int SRC_AW      = 8,
    parameter int WAIT_VBLANK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              size_sel,
    input  logic [1:0]        mode,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [7:0]        dst_x,
    input  logic [6:0]        dst_y,
    input  logic              screenEnd,
    output logic [SRC_AW-1:0] src_addr,
    input  logic              src_data,
    output logic [FB_AW-1:0]  fb_addr,
    input  logic              fb_rdata,
    output logic              fb_wdata,
    output logic              fb_wEn,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);
    import gram_pkg::*;

    blit_state_t       state;
    blit_state_t       state_nxt;
    logic              accept;
    logic              req_size;
    logic [1:0]        req_mode;
    logic [SRC_AW-1:0] req_src;
    logic [7:0]        req_x;
    logic [6:0]        req_y;
    logic              clip;
    logic              last;
    logic              wen_q;

    assign accept = (state == ST_IDLE) && start;

    blit_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .FB_AW  (FB_AW),
        .SRC_AW (SRC_AW)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .advance  (state == ST_WRITE),
        .size_sel (req_size),
        .src_base (req_src),
        .dst_x    (req_x),
        .dst_y    (req_y),
        .src_addr (src_addr),
        .fb_addr  (fb_addr),
        .clip     (clip),
        .last     (last)
    );

    // State register; reset abandons any blit in flight.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: each pixel is one READ then one WRITE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (WAIT_VBLANK != 0) ? ST_WAIT_VB : ST_READ;
            ST_WAIT_VB: if (screenEnd) state_nxt = ST_READ;
            ST_READ:    state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = last ? ST_DONE : ST_READ;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Request capture so the CPU may rewrite its registers mid-blit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_size <= 1'b0;
            req_mode <= MODE_COPY;
            req_src  <= '0;
            req_x    <= 8'd0;
            req_y    <= 7'd0;
        end else if (accept) begin
            req_size <= size_sel;
            req_mode <= mode;
            req_src  <= src_base;
            req_x    <= dst_x;
            req_y    <= dst_y;
        end
    end

    // Write strobe is registered: set on the READ->WRITE edge for visible pixels.
    always_ff @(posedge clk) begin
        if (!reset) wen_q <= 1'b0;
        else        wen_q <= (state == ST_READ) && !clip;
    end

    // Raster-op mux; ROM and GRAM read data are valid during WRITE.
    always_comb begin
        fb_wdata = 1'b0;
        if (state == ST_WRITE) begin
            case (req_mode)
                MODE_COPY: fb_wdata = src_data;
                MODE_OR:   fb_wdata = src_data | fb_rdata;
                MODE_XOR:  fb_wdata = src_data ^ fb_rdata;
                default:   fb_wdata = 1'b0;
            endcase
        end
    end

    assign fb_wEn    = wen_q;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_gram_blitter.sv
`timescale 1ns/1ps
module tb_gram_blitter;
    import gram_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic reset = 1'b0;
    int   cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        start = 1'b0, start1 = 1'b0;
    logic        size_sel = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  src_base = 8'd0;
    logic [7:0]  dst_x = 8'd0;
    logic [6:0]  dst_y = 7'd0;
    logic        screen_end0 = 1'b0, screen_end1 = 1'b0;
    logic [7:0]  src_addr, src_addr1;
    logic        src_data = 1'b0;
    logic        src_data1 = 1'b1;
    logic [14:0] fb_addr, fb_addr1;
    logic        fb_rdata = 1'b0;
    logic        fb_rdata1 = 1'b0;
    logic        fb_wdata, fb_wdata1;
    logic        fb_wen, fb_wen1;
    logic        busy, busy1, done, done1;
    logic [2:0]  state_dbg, state_dbg1;

    gram_blitter #(.WAIT_VBLANK(0)) dut (
        .clk(clk25), .reset(reset), .start(start), .size_sel(size_sel), .mode(mode),
        .src_base(src_base), .dst_x(dst_x), .dst_y(dst_y), .screenEnd(screen_end0),
        .src_addr(src_addr), .src_data(src_data), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .fb_wdata(fb_wdata), .fb_wEn(fb_wen), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    gram_blitter #(.WAIT_VBLANK(1)) dut_vb (
        .clk(clk25), .reset(reset), .start(start1), .size_sel(size_sel), .mode(mode),
        .src_base(src_base), .dst_x(dst_x), .dst_y(dst_y), .screenEnd(screen_end1),
        .src_addr(src_addr1), .src_data(src_data1), .fb_addr(fb_addr1), .fb_rdata(fb_rdata1),
        .fb_wdata(fb_wdata1), .fb_wEn(fb_wen1), .busy(busy1), .done(done1), .state_dbg(state_dbg1)
    );

    // ---------------- memory models ----------------
    logic rom [256];
    logic fb_mem [19200];
    logic shadow [19200];
    logic fb_clr = 1'b0;

    always @(posedge clk25) begin
        src_data <= rom[src_addr];
        fb_rdata <= (fb_addr < 15'd19200) ? fb_mem[fb_addr] : 1'b0;
        if (fb_clr) begin
            for (int i = 0; i < 19200; i++) fb_mem[i] <= 1'b0;
        end else if (fb_wen && fb_addr < 15'd19200) begin
            fb_mem[fb_addr] <= fb_wdata;
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int checks = 0, failures = 0;
    int blit_writes = 0, first_addr = 0, last_addr = 0, min_col = 999, min_row = 999;
    int done_count = 0, done_cyc = 0, start_cyc = 0;
    int wen1_count = 0, first1 = 0, last1 = 0, done1_count = 0, done1_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected write per fb_wEn pulse.
    always @(negedge clk25) begin
        if (fb_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(fb_addr), 32'hFFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("fb_write", {16'd0, fb_addr, fb_wdata}, {16'd0, e});
            end
            if (blit_writes == 0) first_addr = int'(fb_addr);
            last_addr = int'(fb_addr);
            if (int'(fb_addr) % 160 < min_col) min_col = int'(fb_addr) % 160;
            if (int'(fb_addr) / 160 < min_row) min_row = int'(fb_addr) / 160;
            blit_writes++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
            check("busy_in_done", 32'(busy), 32'd0);
        end
        if (fb_wen1) begin
            if (wen1_count == 0) first1 = int'(fb_addr1);
            last1 = int'(fb_addr1);
            wen1_count++;
        end
        if (done1) begin
            done1_count++;
            done1_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rom_fill(input logic all_ones);
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            rom[a] = all_ones ? 1'b1 : (av[0] ^ av[2] ^ av[5]);
        end
    endtask

    // Pushes expected writes (first keep visible pixels, keep<0 = all) then pulses start.
    task automatic issue(input logic sz, input logic [1:0] md, input logic [7:0] sb,
                         input logic [7:0] x, input logic [6:0] y, input int keep);
        int n;
        int pushed;
        n = sz ? 16 : 8;
        pushed = 0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int cs, rs, a;
                logic s, f, d;
                cs = int'(x) + c;
                rs = int'(y) + r;
                if (cs < 160 && rs < 120 && (keep < 0 || pushed < keep)) begin
                    a = rs * 160 + cs;
                    s = rom[(int'(sb) + r * n + c) % 256];
                    f = shadow[a];
                    case (md)
                        2'b00:   d = s;
                        2'b01:   d = s | f;
                        2'b10:   d = s ^ f;
                        default: d = 1'b0;
                    endcase
                    exp_q.push_back({15'(a), d});
                    shadow[a] = d;
                    pushed++;
                end
            end
        end
        blit_writes = 0;
        min_col = 999;
        min_row = 999;
        @(negedge clk25); #1;
        size_sel = sz; mode = md; src_base = sb; dst_x = x; dst_y = y;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk25); #1;
        start = 1'b0;
        // Request fields must already be latched; scramble them.
        dst_x = 8'($urandom_range(0, 255));
        dst_y = 7'($urandom_range(0, 127));
        mode = 2'($urandom_range(0, 3));
        src_base = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = done_count;
        k = 0;
        while (done_count == n0 && k < budget) begin
            @(negedge clk25); #1;
            k++;
        end
        check("done_seen", 32'(done_count - n0), 32'd1);
    endtask

    function automatic int region_ones(input int x0, input int y0, input int n);
        int s;
        s = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                if (fb_mem[(y0 + r) * 160 + x0 + c] === 1'b1) s++;
        return s;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n0, k, mism;
        for (int i = 0; i < 19200; i++) shadow[i] = 1'b0;
        rom_fill(1'b0);

        // Reset state
        reset = 1'b0;
        fb_clr = 1'b1;
        repeat (3) @(negedge clk25);
        #1;
        check("rst_fb_wen", 32'(fb_wen), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b1;
        fb_clr = 1'b0;
        repeat (2) @(negedge clk25);

        // Copy 8x8 at (10,5): 64 writes, 810..1937, done 129 cycles after start
        issue(1'b0, MODE_COPY, 8'd0, 8'd10, 7'd5, -1);
        check("copy_busy", 32'(busy), 32'd1);
        wait_done(400);
        check("copy_writes", 32'(blit_writes), 32'd64);
        check("copy_first_addr", 32'(first_addr), 32'd810);
        check("copy_last_addr", 32'(last_addr), 32'd1937);
        check("copy_done_cycle", 32'(done_cyc - start_cyc), 32'd129);

        // OR and clear over the copied region
        issue(1'b0, MODE_OR, 8'd40, 8'd12, 7'd6, -1);
        wait_done(400);
        check("or_writes", 32'(blit_writes), 32'd64);
        issue(1'b0, MODE_CLR, 8'd7, 8'd14, 7'd5, -1);
        wait_done(400);
        check("clr_writes", 32'(blit_writes), 32'd64);

        // XOR 16x16 twice at (0,0) with all-ones sprite on a cleared region
        rom_fill(1'b1);
        issue(1'b1, MODE_CLR, 8'd0, 8'd0, 7'd0, -1);
        wait_done(1200);
        check("xor_pre_ones", 32'(region_ones(0, 0, 16)), 32'd0);
        issue(1'b1, MODE_XOR, 8'd0, 8'd0, 7'd0, -1);
        wait_done(1200);
        check("xor1_ones", 32'(region_ones(0, 0, 16)), 32'd256);
        issue(1'b1, MODE_XOR, 8'd0, 8'd0, 7'd0, -1);
        wait_done(1200);
        check("xor2_ones", 32'(region_ones(0, 0, 16)), 32'd0);

        // Clip at bottom-right corner: only the 8x8 visible quadrant is written
        rom_fill(1'b0);
        issue(1'b1, MODE_COPY, 8'd3, 8'd152, 7'd112, -1);
        wait_done(1200);
        check("clip_writes", 32'(blit_writes), 32'd64);
        check("clip_min_col", 32'(min_col), 32'd152);
        check("clip_min_row", 32'(min_row), 32'd112);
        check("clip_done_cycle", 32'(done_cyc - start_cyc), 32'd513);

        // start while busy and in the done cycle is ignored
        n0 = done_count;
        issue(1'b0, MODE_COPY, 8'd0, 8'd30, 7'd30, -1);
        repeat (20) @(negedge clk25);
        #1;
        dst_x = 8'd60; dst_y = 7'd60; start = 1'b1;
        @(negedge clk25); #1;
        start = 1'b0;
        check("ignore_busy_high", 32'(busy), 32'd1);
        wait_done(400);
        dst_x = 8'd70; dst_y = 7'd70; start = 1'b1;
        @(negedge clk25); #1;
        start = 1'b0;
        repeat (5) @(negedge clk25);
        #1;
        check("ignore_busy_after", 32'(busy), 32'd0);
        check("ignore_done_pulses", 32'(done_count - n0), 32'd1);
        check("ignore_writes", 32'(blit_writes), 32'd64);

        // WAIT_VBLANK=1 instance: screenEnd in IDLE is not remembered
        size_sel = 1'b0; mode = MODE_COPY; src_base = 8'd0; dst_x = 8'd0; dst_y = 7'd0;
        @(negedge clk25); #1;
        screen_end1 = 1'b1;
        @(negedge clk25); #1;
        screen_end1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk25); #1;
        start1 = 1'b0;
        repeat (500) @(negedge clk25);
        #1;
        check("vb_no_writes", 32'(wen1_count), 32'd0);
        check("vb_busy", 32'(busy1), 32'd1);
        check("vb_state", 32'(state_dbg1), 32'(ST_WAIT_VB));
        screen_end1 = 1'b1;
        start_cyc = cyc;
        @(negedge clk25); #1;
        screen_end1 = 1'b0;
        k = 0;
        while (done1_count == 0 && k < 400) begin
            @(negedge clk25); #1;
            k++;
        end
        check("vb_done", 32'(done1_count), 32'd1);
        check("vb_writes", 32'(wen1_count), 32'd64);
        check("vb_first_addr", 32'(first1), 32'd0);
        check("vb_last_addr", 32'(last1), 32'd1127);
        check("vb_done_cycle", 32'(done1_cyc - start_cyc), 32'd129);

        // Reset in the middle of a 16x16 blit after 20 pixels
        n0 = done_count;
        issue(1'b1, MODE_COPY, 8'd0, 8'd40, 7'd40, 20);
        k = 0;
        while (blit_writes < 20 && k < 200) begin
            @(negedge clk25); #1;
            k++;
        end
        check("rst_mid_reached", 32'(blit_writes), 32'd20);
        reset = 1'b0;
        @(negedge clk25); #1;
        check("rst_mid_wen", 32'(fb_wen), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (600) @(negedge clk25);
        #1;
        check("rst_mid_writes", 32'(blit_writes), 32'd20);
        check("rst_mid_no_done", 32'(done_count - n0), 32'd0);

        // Whole frame buffer against the reference image
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        mism = 0;
        for (int i = 0; i < 19200; i++) if (fb_mem[i] !== shadow[i]) mism++;
        check("fb_image", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time guard
    initial begin
        #20ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
